// File: rtl/base_ram_arbiter_if.sv
// Bundle between the pipeline fetch/data ports, the base SRAM pins and
// the UART strobes. The arbiter uses the slave modport; the requesters
// and the board side (or a testbench) use the master modport.
interface base_ram_arbiter_if;
  // Instruction-fetch port
  logic        if_req;
  logic [19:0] if_adr;
  logic        if_ready;
  logic [31:0] if_rdata;
  // MEM-stage port
  logic        mem_req;
  logic        mem_we;
  logic        mem_uart;
  logic [19:0] mem_adr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  // Base SRAM pins
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n;
  logic        base_ram_oe_n;
  logic        base_ram_we_n;
  logic [31:0] base_ram_data_out;
  logic        base_ram_data_oe;
  logic [31:0] base_ram_data_in;
  // UART strobes
  logic        uart_rdn;
  logic        uart_wrn;

  modport slave (
    input  if_req, if_adr,
    output if_ready, if_rdata,
    input  mem_req, mem_we, mem_uart, mem_adr, mem_be, mem_wdata,
    output mem_ready, mem_rdata,
    output base_ram_addr, base_ram_be_n, base_ram_ce_n, base_ram_oe_n,
    output base_ram_we_n, base_ram_data_out, base_ram_data_oe,
    input  base_ram_data_in,
    output uart_rdn, uart_wrn
  );

  modport master (
    output if_req, if_adr,
    input  if_ready, if_rdata,
    output mem_req, mem_we, mem_uart, mem_adr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata,
    input  base_ram_addr, base_ram_be_n, base_ram_ce_n, base_ram_oe_n,
    input  base_ram_we_n, base_ram_data_out, base_ram_data_oe,
    output base_ram_data_in,
    input  uart_rdn, uart_wrn
  );
endinterface

// File: rtl/base_ram_arbiter.sv
// Base SRAM / UART bus sequencer. Arbitrates the IF and MEM ports and
// produces fixed-timing SRAM and UART strobes, all registered.
// Optional macro BASE_ARB_RR_EN: round-robin arbitration between IF and
// MEM instead of fixed MEM priority.
module base_ram_arbiter #(
  parameter int WR_PULSE   = 2,
  parameter int UART_PULSE = 2,
  parameter int UART_HOLD  = 7
) (
  input logic clk,
  input logic rst_n,
  base_ram_arbiter_if.slave bus
);

  localparam int MAX_AB  = (WR_PULSE > UART_PULSE) ? WR_PULSE : UART_PULSE;
  localparam int MAX_CNT = (MAX_AB > UART_HOLD) ? MAX_AB : UART_HOLD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  // Counter load values: a state lasting N cycles is entered with N-1.
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] UP_LOAD = CW'(UART_PULSE - 1);
  localparam logic [CW-1:0] UH_LOAD = (UART_HOLD > 0) ? CW'(UART_HOLD - 1) : '0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD,
    ST_U_RD, ST_U_WR, ST_U_RECOVER, ST_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          port_mem_reg;   // 1 = current access belongs to MEM
  logic [3:0]    be_reg;         // active-low byte enables of the access
  logic          gnt_mem;
  logic          gnt_any;
  logic [3:0]    cur_be;
  logic          sram_next;

`ifdef BASE_ARB_RR_EN
  logic          last_mem_reg;   // 1 = MEM was granted last
`endif

  // Arbitration decision; only consumed while in IDLE.
  always_comb begin
`ifdef BASE_ARB_RR_EN
    gnt_mem = bus.mem_req && (!bus.if_req || !last_mem_reg);
`else
    gnt_mem = bus.mem_req;
`endif
    gnt_any = bus.mem_req || bus.if_req;
    // Byte enables for the next SRAM cycle: fresh grant or latched access.
    cur_be  = (state_reg == ST_IDLE) ? (gnt_mem ? bus.mem_be : 4'h0) : be_reg;
  end

  // Next-state and dwell-counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (gnt_mem && bus.mem_uart) begin
          state_next = bus.mem_we ? ST_U_WR : ST_U_RD;
          cnt_next   = UP_LOAD;
        end else if (gnt_mem) begin
          state_next = bus.mem_we ? ST_WR_SETUP : ST_RD;
        end else if (gnt_any) begin
          state_next = ST_RD;
        end
      end
      ST_RD:       state_next = ST_DONE;
      ST_WR_SETUP: begin
        state_next = ST_WR_PULSE;
        cnt_next   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_reg == '0) state_next = ST_WR_HOLD;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_WR_HOLD:  state_next = ST_DONE;
      ST_U_RD, ST_U_WR: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (UART_HOLD == 0) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_U_RECOVER;
          cnt_next   = UH_LOAD;
        end
      end
      ST_U_RECOVER: begin
        if (cnt_reg == '0) state_next = ST_DONE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  assign sram_next = state_next inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};

  // State, grant latches and every pin output, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg             <= ST_IDLE;
      cnt_reg               <= '0;
      port_mem_reg          <= 1'b0;
      be_reg                <= 4'hF;
`ifdef BASE_ARB_RR_EN
      last_mem_reg          <= 1'b0;
`endif
      bus.base_ram_addr     <= '0;
      bus.base_ram_be_n     <= 4'hF;
      bus.base_ram_ce_n     <= 1'b1;
      bus.base_ram_oe_n     <= 1'b1;
      bus.base_ram_we_n     <= 1'b1;
      bus.base_ram_data_out <= '0;
      bus.base_ram_data_oe  <= 1'b0;
      bus.uart_rdn          <= 1'b1;
      bus.uart_wrn          <= 1'b1;
      bus.if_ready          <= 1'b0;
      bus.mem_ready         <= 1'b0;
      bus.if_rdata          <= '0;
      bus.mem_rdata         <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if (state_reg == ST_IDLE && gnt_any) begin
        port_mem_reg          <= gnt_mem;
        be_reg                <= cur_be;
        bus.base_ram_addr     <= gnt_mem ? bus.mem_adr : bus.if_adr;
        bus.base_ram_data_out <= gnt_mem ? bus.mem_wdata : 32'h0;
`ifdef BASE_ARB_RR_EN
        last_mem_reg          <= gnt_mem;
`endif
      end

      bus.base_ram_ce_n    <= !sram_next;
      bus.base_ram_oe_n    <= (state_next != ST_RD);
      bus.base_ram_we_n    <= (state_next != ST_WR_PULSE);
      bus.base_ram_be_n    <= sram_next ? cur_be : 4'hF;
      bus.base_ram_data_oe <= state_next inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD, ST_U_WR};
      bus.uart_rdn         <= (state_next != ST_U_RD);
      bus.uart_wrn         <= (state_next != ST_U_WR);
      bus.if_ready         <= (state_next == ST_DONE) && !port_mem_reg;
      bus.mem_ready        <= (state_next == ST_DONE) && port_mem_reg;

      // SRAM read data sampled at the end of RD.
      if (state_reg == ST_RD) begin
        if (port_mem_reg) bus.mem_rdata <= bus.base_ram_data_in;
        else              bus.if_rdata  <= bus.base_ram_data_in;
      end
      // UART byte sampled in the last strobe cycle, zero-extended.
      if (state_reg == ST_U_RD && cnt_reg == '0) begin
        bus.mem_rdata <= {24'h0, bus.base_ram_data_in[7:0]};
      end
    end
  end

endmodule
